// File: rtl/adc_pot_scanner_pkg.sv
// Shared constants and scan-state encoding for the pot/switch scanner.
package adc_pot_scanner_pkg;
    localparam int ADC_W_DEF  = 8;
    localparam int NUM_ADC_CH = 8;
    localparam int CH_W       = 3;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CMP    = 3'd2,
        ST_EMIT   = 3'd3,
        ST_NEXT   = 3'd4
    } scan_state_e;
endpackage

// File: rtl/pot_deadband_cmp.sv
// Deadband filter: decides whether a fresh sample is a reportable move.
module pot_deadband_cmp
    import adc_pot_scanner_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_W_DEF,
    parameter int DEADBAND  = 2
) (
    input  logic [ADC_WIDTH-1:0] s,
    input  logic [ADC_WIDTH-1:0] stored,
    input  logic                 seen,
    output logic                 report
);
    localparam int DW = ADC_WIDTH + 1;

    logic [DW-1:0] d;
    logic          extreme;

    always_comb begin
        if (s >= stored) begin
            d = {1'b0, s} - {1'b0, stored};
        end else begin
            d = {1'b0, stored} - {1'b0, s};
        end
        // End stops always snap through, even inside the deadband
        extreme = (s == '0) || (s == '1);
        report  = !seen || (d > DW'(DEADBAND)) || (extreme && (s != stored));
    end
endmodule

// File: rtl/adc_pot_scanner.sv
// Round-robin ADC channel poller with deadband filtering and change events.
module adc_pot_scanner
    import adc_pot_scanner_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_W_DEF,
    parameter int NUM_CH    = NUM_ADC_CH,
    parameter int DEADBAND  = 2,
    parameter int SCAN_DIV  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [CH_W-1:0]      adc_addr,
    input  logic [ADC_WIDTH-1:0] adc_q,
    input  logic [7:0]           ch_mask,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [CH_W-1:0]      evt_ch,
    output logic [ADC_WIDTH-1:0] evt_val,
    input  logic [CH_W-1:0]      val_addr,
    output logic [ADC_WIDTH-1:0] val_q,
    output logic                 scan_done
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    scan_state_e           state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [ADC_WIDTH-1:0]  s_q, s_d;
    logic                  evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]       evt_ch_q, evt_ch_d;
    logic [ADC_WIDTH-1:0]  evt_val_q, evt_val_d;
    logic                  scan_done_q, scan_done_d;
    logic                  wr_en;
    logic                  report;

    logic [ADC_WIDTH-1:0]  stored_q [NUM_ADC_CH];
    logic [NUM_ADC_CH-1:0] seen_q;

    pot_deadband_cmp #(
        .ADC_WIDTH (ADC_WIDTH),
        .DEADBAND  (DEADBAND)
    ) u_cmp (
        .s      (s_q),
        .stored (stored_q[ch_q]),
        .seen   (seen_q[ch_q]),
        .report (report)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        div_d       = div_q;
        s_d         = s_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_val_d   = evt_val_q;
        scan_done_d = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            ST_WAIT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ch_mask[ch_q] ? ST_SAMPLE : ST_NEXT;
                end
            end
            ST_SAMPLE: begin
                s_d     = adc_q;
                state_d = ST_CMP;
            end
            ST_CMP: begin
                state_d = ST_NEXT;
                if (report) begin
                    wr_en       = 1'b1;
                    evt_ch_d    = ch_q;
                    evt_val_d   = s_q;
                    evt_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Stall the scan until the consumer takes the event
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                ch_d        = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                scan_done_d = (ch_q == CH_LAST);
                div_d       = '0;
                state_d     = ST_WAIT;
            end
            default: begin
                state_d     = ST_WAIT;
                ch_d        = '0;
                div_d       = '0;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT;
            ch_q        <= '0;
            div_q       <= '0;
            s_q         <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_val_q   <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            div_q       <= div_d;
            s_q         <= s_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_val_q   <= evt_val_d;
            scan_done_q <= scan_done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ADC_CH; i++) begin
                stored_q[i] <= '0;
            end
            seen_q <= '0;
        end else if (wr_en) begin
            stored_q[ch_q] <= s_q;
            seen_q[ch_q]   <= 1'b1;
        end
    end

    assign adc_addr  = ch_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_val   = evt_val_q;
    assign scan_done = scan_done_q;
    assign val_q     = stored_q[val_addr];
endmodule
